// File: rtl/arith_cse_pipe.sv
// Two-stage pipelined six-result arithmetic block with valid/ready handshake.
// Stage 1 forms the shared terms S=a+b, P=c*d, T=e-f; stage 2 builds the results.
module arith_cse_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result1,
    output logic [WIDTH-1:0] result2,
    output logic [WIDTH-1:0] result3,
    output logic [WIDTH-1:0] result4,
    output logic [WIDTH-1:0] result5,
    output logic [WIDTH-1:0] result6
);

    logic             s1_valid_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] s_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] t_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] c_r;
    logic [WIDTH-1:0] e_r;
    logic [WIDTH-1:0] f_r;
    logic [WIDTH-1:0] g_r;
    logic [WIDTH-1:0] h_r;

    logic             s1_adv_s;
    logic             s2_adv_s;
    logic             s1_load_s;
    logic             s2_load_s;
    logic [WIDTH-1:0] s_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] t_s;
    logic [WIDTH-1:0] r1_s;
    logic [WIDTH-1:0] r2_s;
    logic [WIDTH-1:0] r3_s;
    logic [WIDTH-1:0] r4_s;
    logic [WIDTH-1:0] r5_s;
    logic [WIDTH-1:0] r6_s;

    // Handshake: a stage advances when it is empty or its successor advances; flush blocks intake.
    always_comb begin
        s2_adv_s  = 1'b0;
        s1_adv_s  = 1'b0;
        in_ready  = 1'b0;
        s1_load_s = 1'b0;
        s2_load_s = 1'b0;
        s2_adv_s  = !s2_valid_r || out_ready;
        s1_adv_s  = !s1_valid_r || s2_adv_s;
        if (flush) begin
            in_ready = 1'b0;
        end else begin
            in_ready = s1_adv_s;
        end
        s1_load_s = in_ready && in_valid;
        s2_load_s = s2_adv_s && s1_valid_r && !flush;
    end

    // Shared terms from the incoming operands and results from the stage-1 terms.
    always_comb begin
        s_s  = a + b;
        p_s  = c * d;
        t_s  = e - f;
        r1_s = s_r + p_r;
        r2_s = p_r + t_r;
        r3_s = s_r + g_r + h_r;
        r4_s = (p_r + e_r) * s_r;
        // (P+b)-(f+S) reduces to c*d - a - f, identical to the unshared form mod 2^WIDTH
        r5_s = (p_r + b_r) - (f_r + s_r);
        r6_s = (s_r + c_r) * t_r;
    end

    // Valid flags; flush empties both stages ahead of any advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= in_valid;
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
            end
        end
    end

    // Stage 1 data: shared terms plus the operands stage 2 still needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r <= {WIDTH{1'b0}};
            p_r <= {WIDTH{1'b0}};
            t_r <= {WIDTH{1'b0}};
            b_r <= {WIDTH{1'b0}};
            c_r <= {WIDTH{1'b0}};
            e_r <= {WIDTH{1'b0}};
            f_r <= {WIDTH{1'b0}};
            g_r <= {WIDTH{1'b0}};
            h_r <= {WIDTH{1'b0}};
        end else if (s1_load_s) begin
            s_r <= s_s;
            p_r <= p_s;
            t_r <= t_s;
            b_r <= b;
            c_r <= c;
            e_r <= e;
            f_r <= f;
            g_r <= g;
            h_r <= h;
        end
    end

    // Stage 2 data: result registers hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result1 <= {WIDTH{1'b0}};
            result2 <= {WIDTH{1'b0}};
            result3 <= {WIDTH{1'b0}};
            result4 <= {WIDTH{1'b0}};
            result5 <= {WIDTH{1'b0}};
            result6 <= {WIDTH{1'b0}};
        end else if (s2_load_s) begin
            result1 <= r1_s;
            result2 <= r2_s;
            result3 <= r3_s;
            result4 <= r4_s;
            result5 <= r5_s;
            result6 <= r6_s;
        end
    end

    assign out_valid = s2_valid_r;

endmodule
